// File: rtl/squarewave_generator_multi.sv
`default_nettype none
// squarewave_generator_multi: N-channel square/PWM/one-shot generator. Each channel has shadowed config
// that is applied at period wrap, or at once while the channel is idle. Rev 1.0 - initial release.
module squarewave_generator_multi #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int AMP_W    = 6,
  parameter int PRESCALE = 1,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    sysclk,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [1:0]              cfg_mode,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [CNT_W-1:0]        cfg_duty,
  input  logic [AMP_W-1:0]        cfg_amp,
  input  logic [NUM_CH-1:0]       enable,
  output logic [NUM_CH-1:0]       wave_out,
  output logic [NUM_CH*AMP_W-1:0] amp_out,
  output logic [AMP_W+CH_W-1:0]   mix_out,
  output logic [NUM_CH-1:0]       wrap_tick
);

  localparam logic [1:0] MODE_SQUARE  = 2'd0;
  localparam logic [1:0] MODE_PWM     = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;
  localparam logic [1:0] MODE_OFF     = 2'd3;

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int              MIX_W   = AMP_W + CH_W;

  logic [PS_W-1:0]   presc;
  logic              tick;
  logic              hs;
  logic [NUM_CH-1:0] pending;
  logic [MIX_W-1:0]  mix_sum;

  assign tick      = (presc == PS_LAST);
  assign cfg_ready = !pending[cfg_ch];
  assign hs        = cfg_valid && cfg_ready;

  always_ff @(posedge sysclk) begin
    if (reset || tick) presc <= '0;
    else               presc <= presc + PS_ONE;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       mode, sh_mode, e_mode;
    logic [CNT_W-1:0] period, duty, sh_period, sh_duty, e_period, e_duty;
    logic [CNT_W-1:0] cnt, cnt_inc, e_high;
    logic [AMP_W-1:0] amp, sh_amp;
    logic             pend, done, en_d, wave, wrap_r;
    logic             sel_wr, run, last, wrap, apply;

    assign sel_wr = hs && (cfg_ch == CH_W'(i));
    assign run    = enable[i] && (mode != MODE_OFF) && (period != '0) && !done;
    assign last   = (cnt == period - CNT_ONE);
    assign wrap   = tick && run && last;
    // An idle channel (disabled, off, period 0 or finished one-shot) takes its shadow immediately.
    assign apply  = pend && (wrap || !run);

    assign e_mode   = apply ? sh_mode   : mode;
    assign e_period = apply ? sh_period : period;
    assign e_duty   = apply ? sh_duty   : duty;
    assign cnt_inc  = last ? '0 : cnt + CNT_ONE;

    always_comb begin
      e_high = '0;
      case (e_mode)
        MODE_SQUARE:            e_high = e_period >> 1;
        MODE_PWM, MODE_ONESHOT: e_high = (e_duty < e_period) ? e_duty : e_period;
        default:                e_high = '0;
      endcase
    end

    always_ff @(posedge sysclk) begin
      if (reset) begin
        mode <= MODE_OFF;   period <= '0;    duty <= '0;    amp <= '0;
        sh_mode <= MODE_OFF; sh_period <= '0; sh_duty <= '0; sh_amp <= '0;
        pend <= 1'b0; done <= 1'b0; en_d <= 1'b0;
        cnt <= '0; wave <= 1'b0; wrap_r <= 1'b0;
      end else begin
        en_d   <= enable[i];
        wrap_r <= 1'b0;
        if (apply) begin
          mode <= sh_mode; period <= sh_period; duty <= sh_duty; amp <= sh_amp;
        end
        // A write landing on the apply cycle replaces the shadow after it was consumed.
        if (sel_wr) begin
          sh_mode <= cfg_mode; sh_period <= cfg_period; sh_duty <= cfg_duty; sh_amp <= cfg_amp;
          pend    <= 1'b1;
        end else if (apply) begin
          pend <= 1'b0;
        end
        if (!enable[i] || e_mode == MODE_OFF) begin
          cnt <= '0; wave <= 1'b0; done <= 1'b0;
        end else if (!en_d || (apply && !wrap)) begin
          cnt <= '0; done <= 1'b0; wave <= (e_high != '0);
        end else if (tick && run) begin
          cnt    <= cnt_inc;
          wrap_r <= wrap;
          if (wrap && !apply && mode == MODE_ONESHOT) begin
            done <= 1'b1;
            wave <= 1'b0;
          end else begin
            wave <= (cnt_inc < e_high);
          end
        end
      end
    end

    assign pending[i]                 = pend;
    assign wave_out[i]                = wave;
    assign wrap_tick[i]               = wrap_r;
    assign amp_out[i*AMP_W +: AMP_W]  = wave ? amp : '0;
  end

  always_comb begin
    mix_sum = '0;
    for (int j = 0; j < NUM_CH; j++) mix_sum = mix_sum + MIX_W'(amp_out[j*AMP_W +: AMP_W]);
  end

  always_ff @(posedge sysclk) begin
    if (reset) mix_out <= '0;
    else       mix_out <= mix_sum;
  end

endmodule
`default_nettype wire
